fir_mac_banked: RTL



---
 rtl/fir_mac_banked.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fir_mac_banked.sv
// Time-multiplexed FIR: one MAC walks a circular delay line against one of
// NBANK runtime-writable coefficient banks, then rounds and saturates.
module fir_mac_banked #(
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int TAPS  = 32,
    parameter int NBANK = 4,
    parameter int FRAC  = 15,
    localparam int BW   = (NBANK > 1) ? $clog2(NBANK) : 1,
    localparam int AW   = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          smpl_vld,
    input  logic [DW-1:0] smpl_in,
    input  logic [BW-1:0] bank_sel,
    output logic          busy,
    input  logic          cff_we,
    input  logic [BW-1:0] cff_bank,
    input  logic [AW-1:0] cff_addr,
    input  logic [CW-1:0] cff_wdata,
    output logic [DW-1:0] smpl_out,
    output logic          smpl_out_vld,
    output logic          sat_flag,
    output logic          ovr_err,
    output logic          cff_err
);

    localparam int PW   = DW + CW;
    localparam int ACCW = DW + CW + AW;

    localparam logic [AW-1:0] LAST = AW'(TAPS - 1);
    localparam logic signed [ACCW-1:0] HALF =
        {{(ACCW-1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic [DW-1:0] POS_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] NEG_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        MAC,
        OUT
    } state_t;

    state_t state;

    logic signed [CW-1:0] cmem  [NBANK][TAPS];
    logic signed [DW-1:0] dline [TAPS];

    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW-1:0] idx;
    logic [AW-1:0] cnt;
    logic [BW-1:0] bank;

    logic signed [CW-1:0]   coef;
    logic signed [DW-1:0]   tap;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] shf;

    logic wr_hit;
    logic wr_ok;
    logic fits;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a);
        return (a == LAST) ? '0 : a + 1'b1;
    endfunction

    function automatic logic [AW-1:0] prv(input logic [AW-1:0] a);
        return (a == '0) ? LAST : a - 1'b1;
    endfunction

    // The bank being filtered is frozen for the whole computation.
    assign wr_hit = busy && (cff_bank == bank);
    assign wr_ok  = cff_we && !wr_hit
                 && (int'(cff_bank) < NBANK)
                 && (int'(cff_addr) < TAPS);

    assign prod = PW'(coef) * PW'(tap);
    assign shf  = (acc + HALF) >>> FRAC;

    // Result fits when every bit above the sign position matches it.
    assign fits = (&shf[ACCW-1:DW-1]) | ~(|shf[ACCW-1:DW-1]);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            cmem[cff_bank][cff_addr] <= cff_wdata;
        end
        coef <= cmem[bank][idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            smpl_out     <= '0;
            smpl_out_vld <= 1'b0;
            sat_flag     <= 1'b0;
            ovr_err      <= 1'b0;
            cff_err      <= 1'b0;
            wp           <= '0;
            rp           <= '0;
            idx          <= '0;
            cnt          <= '0;
            bank         <= '0;
            acc          <= '0;
            tap          <= '0;
            for (int i = 0; i < TAPS; i++) begin
                dline[i] <= '0;
            end
        end else begin
            smpl_out_vld <= 1'b0;
            sat_flag     <= 1'b0;

            if (cff_we && wr_hit) begin
                cff_err <= 1'b1;
            end
            if (smpl_vld && busy) begin
                ovr_err <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (smpl_vld) begin
                        dline[wp] <= smpl_in;
                        bank      <= bank_sel;
                        rp        <= wp;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    acc   <= '0;
                    tap   <= dline[rp];
                    rp    <= prv(rp);
                    idx   <= nxt(idx);
                    cnt   <= '0;
                    state <= MAC;
                end
                MAC: begin
                    acc <= acc + {{AW{prod[PW-1]}}, prod};
                    tap <= dline[rp];
                    rp  <= prv(rp);
                    idx <= nxt(idx);
                    cnt <= nxt(cnt);
                    if (cnt == LAST) begin
                        state <= OUT;
                    end
                end
                OUT: begin
                    if (fits) begin
                        smpl_out <= shf[DW-1:0];
                    end else begin
                        smpl_out <= shf[ACCW-1] ? NEG_MIN : POS_MAX;
                    end
                    sat_flag     <= !fits;
                    smpl_out_vld <= 1'b1;
                    wp           <= nxt(wp);
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
